uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Receive control unit for the UART RX path. Validates a detected start bit and runs the bit timer for one frame.
//  Checks the stop bit, pulses the RX buffer load, and keeps data_ready/overrun/framing status for the host side.
//  Sits between the start-bit edge detector, the bit timer, the shift register and the RX data buffer.
// PARAMETERS
//  CLKS_PER_BIT  10  clocks per serial bit; must match the timer's rollover
//  START_CHK     5   clocks serial_in must stay low after the start edge (mid-bit check); 1..CLKS_PER_BIT-1
// PORTS
//  clk                 in   1  system clock, rising edge
//  n_rst               in   1  asynchronous active-low reset
//  serial_in           in   1  synchronized serial line (idle high)
//  start_bit_detected  in   1  1-cycle pulse: falling edge seen on serial_in
//  packet_done         in   1  1-cycle pulse from bit timer: all frame bits shifted
//  stop_bit            in   1  last sampled bit (stop bit position) from shift register
//  data_read           in   1  host has consumed the RX buffer
//  enable_timer        out  1  run the bit timer; timer self-clears when low
//  sbc_clear           out  1  1-cycle pulse clearing the stop-bit/shift state at frame start
//  load_buffer         out  1  1-cycle pulse: copy shift register into RX buffer
//  data_ready          out  1  RX buffer holds unread data
//  overrun_error       out  1  frame loaded while previous data unread
//  framing_error       out  1  last frame had stop_bit==0
//  busy                out  1  state != IDLE
// BEHAVIOUR
//  - Reset (async, n_rst=0): state IDLE, start counter 0, all outputs 0. Reset mid-frame aborts the frame with no load and no flags.
//  - States: IDLE, START_CHK, RECEIVE, STOP_CHK, LOAD.
//  - IDLE: on start_bit_detected -> START_CHK; sbc_clear=1 that cycle; start counter cleared.
//  - START_CHK: counter increments each cycle. If serial_in==1 on any cycle -> IDLE (glitch; no flags change).
//    When the counter reaches START_CHK with serial_in==0 -> RECEIVE. framing_error is cleared on this transition.
//  - RECEIVE: enable_timer=1 (registered, asserted first cycle in RECEIVE). On packet_done -> STOP_CHK.
//    start_bit_detected is ignored outside IDLE.
//  - STOP_CHK (1 cycle): enable_timer=0. stop_bit==1 -> LOAD. stop_bit==0 -> framing_error<=1, -> IDLE, no load.
//  - LOAD (1 cycle): load_buffer=1, data_ready<=1; if data_ready==1 && !data_read -> overrun_error<=1. -> IDLE.
//  - data_read: clears data_ready and overrun_error next edge. It has no effect on framing_error.
//    Same cycle as LOAD: the load wins; data_ready stays 1 and overrun is not set.
//  - Latency: start_bit_detected -> enable_timer = START_CHK+1 cycles. packet_done -> load_buffer = 2 cycles.
//  - All outputs are registered or decoded from the state register only. There are no combinational input->output paths.
//  - Start counter width $clog2(CLKS_PER_BIT). It saturates and never wraps.
// CONFIGURATION
//  UART_RX_BREAK_DETECT_EN defined:
//    - Adds input rx_data_zero (1: all shifted data bits are 0) and output break_detected.
//    - In STOP_CHK, stop_bit==0 && rx_data_zero==1 sets break_detected, and also sets framing_error.
//    - break_detected is cleared by data_read or by the next START_CHK->RECEIVE transition. Reset value is 0.
//  Not defined: both ports are absent; behaviour is exactly as above.
// STRUCTURE
//  - uart_rx_pkg holds:
//    - rx_state_t: enum logic [2:0] {IDLE, START_CHK, RECEIVE, STOP_CHK, LOAD}.
//    - Default constants UART_CLKS_PER_BIT=10 and UART_START_CHK=5, shared with the timer instance.
//  - The start-check counter is one flex_counter instance: rollover_val=START_CHK, clear on IDLE.
//  - No other sub-modules.
// TESTING
//  1. Clean frame with stop=1, data_read low:
//     - enable_timer rises 6 cycles after start_bit_detected.
//     - load_buffer pulses 2 cycles after packet_done, and data_ready=1.
//  2. Glitch: serial_in returns high 3 cycles after start_bit_detected -> back to IDLE.
//     enable_timer, load_buffer and all flags stay 0.
//  3. Stop bit 0 -> framing_error=1, no load_buffer pulse. The next good frame clears framing_error on entering RECEIVE.
//  4. Two good frames with no data_read -> overrun_error=1 after the 2nd LOAD. data_read=1 clears data_ready and overrun.
//  5. data_read asserted in the LOAD cycle -> data_ready stays 1 and overrun_error stays 0.
//  6. n_rst pulsed mid-RECEIVE -> all outputs 0 immediately, IDLE. With _EN: an all-zero frame with stop=0 sets break_detected=1.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and default timing constants for the UART receive path.
// Optional break detection in uart_rx_ctrl is enabled by UART_RX_BREAK_DETECT_EN.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        RECEIVE,
        STOP_CHK,
        LOAD
    } rx_state_t;

    localparam int UART_CLKS_PER_BIT = 10;
    localparam int UART_START_CHK    = 5;

endpackage

// File: rtl/uart_rx_ctrl_flex_counter.sv
// Up-counter with synchronous clear that stops at rollover_val instead of wrapping.
module flex_counter #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                count_enable,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count_out
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable && (count_out != rollover_val)) begin
            count_out <= count_out + NUM_BITS'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: start-bit validation, timer enable, stop check, buffer load and status.
// Defining UART_RX_BREAK_DETECT_EN adds rx_data_zero / break_detected.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int START_CHK    = UART_START_CHK
) (
    input  logic clk,
    input  logic n_rst,
    input  logic serial_in,
    input  logic start_bit_detected,
    input  logic packet_done,
    input  logic stop_bit,
    input  logic data_read,
`ifdef UART_RX_BREAK_DETECT_EN
    input  logic rx_data_zero,
    output logic break_detected,
`endif
    output logic enable_timer,
    output logic sbc_clear,
    output logic load_buffer,
    output logic data_ready,
    output logic overrun_error,
    output logic framing_error,
    output logic busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    rx_state_t        state;
    rx_state_t        next_state;
    logic [CNT_W-1:0] start_cnt;
    logic             chk_done;
    logic             enter_rx;

    flex_counter #(
        .NUM_BITS(CNT_W)
    ) start_counter (
        .clk         (clk),
        .n_rst       (n_rst),
        .clear       (state == IDLE),
        .count_enable(state == uart_rx_pkg::START_CHK),
        .rollover_val(CNT_W'(START_CHK)),
        .count_out   (start_cnt)
    );

    // The counter steps to START_CHK on the same edge that leaves START_CHK, so the
    // line is sampled low on exactly START_CHK cycles before the timer starts.
    assign chk_done = (start_cnt == CNT_W'(START_CHK - 1));
    assign enter_rx = (state == uart_rx_pkg::START_CHK) && !serial_in && chk_done;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_bit_detected) begin
                    next_state = uart_rx_pkg::START_CHK;
                end
            end
            uart_rx_pkg::START_CHK: begin
                if (serial_in) begin
                    next_state = IDLE;
                end else if (chk_done) begin
                    next_state = RECEIVE;
                end
            end
            RECEIVE: begin
                if (packet_done) begin
                    next_state = STOP_CHK;
                end
            end
            STOP_CHK: next_state = stop_bit ? LOAD : IDLE;
            LOAD:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    assign load_buffer = (state == LOAD);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            enable_timer  <= 1'b0;
            sbc_clear     <= 1'b0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            enable_timer <= (next_state == RECEIVE);
            sbc_clear    <= (state == IDLE) && start_bit_detected;

            // A read coinciding with the load consumes the old word, so no overrun.
            if (state == LOAD) begin
                data_ready    <= 1'b1;
                overrun_error <= data_read ? 1'b0 : (overrun_error | data_ready);
            end else if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end

            if (enter_rx) begin
                framing_error <= 1'b0;
            end else if ((state == STOP_CHK) && !stop_bit) begin
                framing_error <= 1'b1;
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            break_detected <= 1'b0;
        end else if ((state == STOP_CHK) && !stop_bit && rx_data_zero) begin
            break_detected <= 1'b1;
        end else if (data_read || enter_rx) begin
            break_detected <= 1'b0;
        end
    end
`endif

endmodule
